// File: rtl/priority_arb_pkg.sv
// Shared types and constants for the priority grant arbiter.
package priority_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned MAX_ID_W = 4;
    localparam int unsigned HOLD_W   = 8;

endpackage

// File: rtl/priority_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface priority_grant_arbiter_if #(
    parameter int unsigned N_REQ = 16,
    parameter int unsigned ID_W  = $clog2(N_REQ)
);
    import priority_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             release_i;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic             timeout;
    logic             busy;

    modport master (
        output req, release_i,
        input  gnt, gnt_valid, gnt_id, timeout, busy
    );

    modport slave (
        input  req, release_i,
        output gnt, gnt_valid, gnt_id, timeout, busy
    );

endinterface

// File: rtl/prio_find_high.sv
// Combinational highest-set-bit finder: found flag plus binary index.
module prio_find_high #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Ascending scan: the last set bit seen is the highest and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/priority_grant_arbiter.sv
// Registered descending-priority arbiter with hold timeout.
// Optional rotating priority when PRIORITY_ARB_ROUND_ROBIN_EN is defined.
module priority_grant_arbiter
    import priority_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 16,
    parameter int unsigned ID_W     = $clog2(N_REQ),
    parameter int unsigned MAX_HOLD = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    priority_grant_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic [N_REQ-1:0]   req_ord;
    logic               find_ok;
    logic [ID_W-1:0]    find_idx;
    logic [ID_W-1:0]    win_id;
    logic               owner_req;
    logic               hold_done;

`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W:0]      id_sum;

    // Rotate so bit (ptr-1) lands on the top position, then undo the rotation.
    always_comb begin
        req_ord = N_REQ'({bus.req, bus.req} >> ptr_q);
        id_sum  = {1'b0, find_idx} + {1'b0, ptr_q};
        if (id_sum >= (ID_W + 1)'(N_REQ)) begin
            id_sum = id_sum - (ID_W + 1)'(N_REQ);
        end
        win_id  = id_sum[ID_W-1:0];
    end
`else
    always_comb begin
        req_ord = bus.req;
        win_id  = find_idx;
    end
`endif

    prio_find_high #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_find (
        .vec   (req_ord),
        .found (find_ok),
        .idx   (find_idx)
    );

    assign owner_req = |(bus.req & gnt_q);
    assign hold_done = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        timeout_d   = 1'b0;
        hold_d      = hold_q;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (find_ok) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << win_id;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win_id;
                    hold_d      = '0;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
                    ptr_d       = win_id;
`endif
                end
            end
            GRANT: begin
                // A normal release or request drop suppresses the timeout pulse.
                if (bus.release_i || !owner_req || hold_done) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    timeout_d   = !bus.release_i && owner_req;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
            hold_q      <= '0;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timeout_q   <= timeout_d;
            hold_q      <= hold_d;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Self-checking bench: directed plan steps plus randomized traffic against a behavioural model.
module tb_priority_grant_arbiter;

    localparam int N  = 16;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    priority_grant_arbiter_if #(.N_REQ(N), .ID_W(4)) bus_if ();

    priority_grant_arbiter #(
        .N_REQ    (N),
        .ID_W     (4),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 when idle), cycles held so far, last owner.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    function automatic int pick(logic [15:0] r);
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr - k + N) % N;
            if (r[idx]) return idx;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] r;
        logic        rel;
        r   = bus_if.req;
        rel = bus_if.release_i;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (r != 16'h0) begin
                m_owner = pick(r);
                m_ptr   = m_owner;
                m_held  = 1;
            end
        end else if (rel || !r[m_owner]) begin
            m_owner = -1;
        end else if (MH != 0 && m_held == MH) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, ".gnt"},       32'(bus_if.gnt),       eg);
        chk({tag, ".gnt_valid"}, 32'(bus_if.gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".gnt_id"},    32'(bus_if.gnt_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".timeout"},   32'(bus_if.timeout),   32'(m_to));
        chk({tag, ".busy"},      32'(bus_if.busy),      32'(m_owner >= 0));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        chk_model(tag);
    endtask

    initial begin
        int vcnt;
        int tcnt;
        int exp_id;

        // Reset with everyone requesting, then idle out of reset
        rst_n            = 1'b0;
        bus_if.req       = 16'hFFFF;
        bus_if.release_i = 1'b0;
        model_reset();
        #12;
        chk_model("rst");
        bus_if.req = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick("idle");

        // Fixed priority and no preemption
        bus_if.req = 16'h0005;
        tick("g2");
        chk("id2", 32'(bus_if.gnt_id), 32'd2);
        chk("gnt4", 32'(bus_if.gnt), 32'h4);
        bus_if.req = 16'h8005;
        tick("nopre");
        chk("id2_hold", 32'(bus_if.gnt_id), 32'd2);
        bus_if.release_i = 1'b1;
        tick("rel");
        chk("rel_low", 32'(bus_if.gnt_valid), 32'd0);
        bus_if.release_i = 1'b0;
        tick("regrant");
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
        exp_id = 0;
`else
        exp_id = 15;
`endif
        chk("id_after_rel", 32'(bus_if.gnt_id), 32'(exp_id));

        // Owner drops its request
        bus_if.req = 16'h0000;
        tick("drop0");
        bus_if.req = 16'h0080;
        tick("g7");
        chk("id7", 32'(bus_if.gnt_id), 32'd7);
        tick("g7b");
        bus_if.req = 16'h0000;
        tick("drop7");
        chk("drop_valid", 32'(bus_if.gnt_valid), 32'd0);
        chk("drop_to", 32'(bus_if.timeout), 32'd0);

        // Timeout after exactly MH cycles
        bus_if.req = 16'h0008;
        vcnt = 0;
        tcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick("to");
            if (bus_if.gnt_valid === 1'b1) vcnt++;
            if (bus_if.timeout === 1'b1) tcnt++;
        end
        chk("hold_len", 32'(vcnt), 32'(MH));
        chk("to_pulses", 32'(tcnt), 32'd1);
        tick("to_regrant");
        chk("to_regrant_id", 32'(bus_if.gnt_id), 32'd3);
        repeat (3) tick("to_hold");
        bus_if.release_i = 1'b1;
        tick("rel_last");
        chk("rel_last_valid", 32'(bus_if.gnt_valid), 32'd0);
        chk("rel_wins", 32'(bus_if.timeout), 32'd0);
        bus_if.release_i = 1'b0;
        bus_if.req = 16'h0000;
        tick("quiet");

        // Asynchronous reset in the middle of a grant
        bus_if.req = 16'h0010;
        tick("pre_rst");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_gnt", 32'(bus_if.gnt), 32'd0);
        chk_model("arst");
        bus_if.req = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_rst");
        chk("post_rst_id", 32'(bus_if.gnt_id), 32'd15);

        // Grant sequence with all requesting and a release after each grant
        for (int k = 1; k <= 16; k++) begin
            bus_if.release_i = 1'b1;
            tick("seq_rel");
            bus_if.release_i = 1'b0;
            tick("seq_g");
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
            exp_id = (31 - k) % 16;
`else
            exp_id = 15;
`endif
            chk("seq_id", 32'(bus_if.gnt_id), 32'(exp_id));
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus_if.req = 16'h0000;
                    1:       bus_if.req = 16'h1 << $urandom_range(0, 15);
                    default: bus_if.req = 16'($urandom);
                endcase
            end
            bus_if.release_i = ($urandom_range(0, 5) == 0);
            tick("rand");
        end
        bus_if.release_i = 1'b0;
        bus_if.req = 16'h0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_grant_arbiter.md
# priority_grant_arbiter

Shares one downstream resource among up to 16 requesters using the team's descending-index priority (highest index wins). Registered grant, held until the owner releases, drops its request, or hits a hold timeout. Sits between the request pins and the shared datapath, and supplies the binary owner ID the datapath needs. An optional round-robin mode rotates priority after each grant.

## Interface
- `N_REQ`, 16: number of requesters, 2..16.
- `ID_W`, $clog2(N_REQ): width of the owner ID.
- `MAX_HOLD`, 255: maximum grant length in cycles, 1..255; 0 disables the timeout.
- `clk` input 1: the single clock; everything is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: level requests, one bit per requester.
- `release_i` input 1: single-cycle release strobe from the current owner.
- `gnt` output N_REQ: one-hot grant, all zero when idle.
- `gnt_valid` output 1: a grant is active.
- `gnt_id` output ID_W: binary index of the owner, 0 when `gnt_valid`=0.
- `timeout` output 1: one-cycle pulse when a grant is force-released.
- `busy` output 1: high when the state is GRANT.

## Operation
- States: IDLE, GRANT.
- Reset values: state=IDLE, `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout`=0, `busy`=0, hold counter=0, rotation pointer=0.
- **IDLE:**
  - If `req`≠0, select a winner by priority order, register it into `gnt`/`gnt_id`, set `gnt_valid`=1 and go to GRANT.
  - If `req`=0, stay in IDLE with all outputs 0.
- **GRANT:** `gnt`, `gnt_id` and `gnt_valid` are frozen. Requests from other requesters are ignored, with no preemption.
- **Exit from GRANT** to IDLE occurs on any of the following, each checked every cycle:
  - `release_i`=1;
  - `req[gnt_id]`=0;
  - the hold counter equals MAX_HOLD-1 (only when MAX_HOLD≠0).
- **Timeout exit:** `timeout`=1 during the first IDLE cycle, but only if neither `release_i` nor the owner's request drop happened in the same cycle. A normal release wins over a timeout.
- **Hold counter:**
  - 8 bits, cleared on GRANT entry and incremented once per GRANT cycle.
  - Saturates and does not wrap.
  - With MAX_HOLD=0 it is ignored.
- **`release_i` in IDLE** is ignored.
- **Fixed priority:** the highest set index wins. For example, `req`=0x8001 grants ID 15.
- **Asynchronous reset mid-grant:** all outputs clear immediately. After `rst_n` rises, arbitration restarts from IDLE and the pointer is back to 0.

## Timing
- **Grant latency:** `req` seen in IDLE at edge t gives `gnt_valid`=1 after edge t+1, i.e. one cycle.
- **Release latency:** `release_i` sampled at edge t gives `gnt_valid`=0 after edge t+1.
- **Minimum gap between grants:** exactly one IDLE cycle. The next grant appears at edge t+2 at the earliest.
- **Maximum grant length:** exactly MAX_HOLD cycles of `gnt_valid`=1.
- **Output registers:** all outputs come directly from registers, with no combinational path from `req` to `gnt`.

## Configuration
- Macro: `PRIORITY_ARB_ROUND_ROBIN_EN`.
- **Defined:**
  - A rotation pointer `ptr` (ID_W bits) loads the granted ID on each grant.
  - The next arbitration order is ptr-1, ptr-2, …, 0, N_REQ-1, …, ptr, descending with wrap-around, so the last owner has the lowest priority.
  - With ptr=0 after reset, the order is identical to fixed priority.
- **Undefined:**
  - No pointer register exists.
  - Fixed priority applies: the highest set index always wins.

## Structure
- **Package `priority_arb_pkg`:** the state enum (IDLE, GRANT), the `MAX_ID_W`=4 constant, and the hold-counter width constant (8).
- **Sub-module `prio_find_high`:** combinational highest-set-bit finder over N_REQ bits, returning a found flag and a binary index.
  - Round-robin mode uses it on the request vector rotated by `ptr`, then adds `ptr` back to the index modulo N_REQ.

## Test plan
- **Reset and idle:** `rst_n`=0 with `req`=0xFFFF → all outputs 0. Release reset with `req`=0 → outputs stay 0 for 10 cycles.
- **Fixed priority:**
  - `req`=0x0005 → `gnt_id`=2, `gnt`=0x0004 one cycle later.
  - Add `req`=0x8005 mid-grant → grant is unchanged.
  - `release_i` → gnt low for one cycle, then `gnt_id`=15.
- **Request drop:** owner 7 deasserts `req[7]` → `gnt_valid`=0 next cycle and `timeout`=0.
- **Timeout:**
  - MAX_HOLD=4 with owner 3 holding → `gnt_valid` high for exactly 4 cycles, then `timeout` pulses for 1 cycle.
  - `release_i` on the 4th cycle → no timeout pulse.
- **Round robin (macro defined):** `req`=0xFFFF held, with `release_i` after every grant → ID sequence 15, 14, 13, …, 0, 15. Without the macro, the sequence is 15 every time.
- **Async reset mid-grant:** assert `rst_n`=0 between clock edges during a GRANT → `gnt`=0 immediately. The first grant after reset follows fixed order (ID 15 for `req`=0xFFFF).
